// File: rtl/peripherals_intc.sv
// ---------------------------------------------------------------------------
// peripherals_intc
//
// Parametrised interrupt controller on the memory-mapped Wishbone register
// port. Each external source is synchronised, optionally edge-detected,
// latched into a pending bit, masked by ENABLE and priority-encoded (lowest
// index wins) into int_gen / int_id for the core.
//
// Register map (word addresses relative to BASE_ADDR):
//   +0 SOURCE   RO  synchronised irq_in
//   +1 ENABLE   RW  per-source enable
//   +2 PENDING  RO  pending bits; writing 1 clears edge-mode bits
//   +3 MODE     RW  1 = rising edge, 0 = level
//   +4 CLAIM    RO  int_gen ? int_id+1 : 0; reading clears the claimed
//                   edge-mode pending bit
//
// Optional feature macro: INTC_EDGE_MODE_EN
//   defined   - MODE register, edge detect, W1C and claim-clear present
//   undefined - all sources level-sensitive, MODE reads 0, W1C and the
//               claim side effect are ignored (CLAIM still reports the id)
//
// Ports:
//   clk, reset (async, active-high), sync_reset (synchronous clear)
//   irq_in        asynchronous interrupt sources, active-high
//   WB_RD_*       read port: strobe, address, registered data, ack
//   WB_WR_*       write port: strobe, write enable, byte select, address,
//                 data, ack
//   int_gen       any enabled pending source
//   int_id        lowest-index enabled pending source (0 when int_gen=0)
// ---------------------------------------------------------------------------
module peripherals_intc #(
    parameter int                    NUM_INT     = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    XLEN        = 32,
    parameter int                    ADDR_BITS   = 8,
    parameter logic [ADDR_BITS-1:0]  BASE_ADDR   = 'h20,
    localparam int                   ID_W        = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_reset,
    input  logic [NUM_INT-1:0]    irq_in,
    input  logic                  WB_RD_STB_I,
    input  logic [ADDR_BITS-1:0]  WB_RD_ADR_I,
    output logic [XLEN-1:0]       WB_RD_DAT_O,
    output logic                  WB_RD_ACK_O,
    input  logic                  WB_WR_STB_I,
    input  logic                  WB_WR_WE_I,
    input  logic [XLEN/8-1:0]     WB_WR_SEL_I,
    input  logic [ADDR_BITS-1:0]  WB_WR_ADR_I,
    input  logic [XLEN-1:0]       WB_WR_DAT_I,
    output logic                  WB_WR_ACK_O,
    output logic                  int_gen,
    output logic [ID_W-1:0]       int_id
);

    localparam logic [ADDR_BITS-1:0] ADR_SOURCE  = BASE_ADDR;
    localparam logic [ADDR_BITS-1:0] ADR_ENABLE  = BASE_ADDR + ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADR_PENDING = BASE_ADDR + ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] ADR_MODE    = BASE_ADDR + ADDR_BITS'(3);
    localparam logic [ADDR_BITS-1:0] ADR_CLAIM   = BASE_ADDR + ADDR_BITS'(4);

    // Synchroniser chain; the last stage is the clean source vector.
    logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q;
    logic [NUM_INT-1:0]                  src_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else if (sync_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
        end
    end

    assign src_s = sync_q[SYNC_STAGES-1];

    // Write decode with byte-lane masking; bits above NUM_INT are dropped.
    logic            wr_en;
    logic            wr_enable_hit;
    logic [XLEN-1:0] wr_mask;
    logic [XLEN-1:0] wr_bits;
    logic            unused_wr;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < XLEN/8; b++) begin
            wr_mask[b*8 +: 8] = {8{WB_WR_SEL_I[b]}};
        end
    end

    assign wr_en         = WB_WR_STB_I & WB_WR_WE_I;
    assign wr_bits       = WB_WR_DAT_I & wr_mask;
    assign wr_enable_hit = wr_en && (WB_WR_ADR_I == ADR_ENABLE);
    assign unused_wr     = ^{wr_bits, wr_mask};

    logic [NUM_INT-1:0] enable_q;
    logic [NUM_INT-1:0] pending_q;
    logic [NUM_INT-1:0] pending_next;
    logic [NUM_INT-1:0] mode_w;
    logic [NUM_INT-1:0] active;
    logic [ID_W-1:0]    prio_id;

`ifdef INTC_EDGE_MODE_EN
    logic [NUM_INT-1:0] mode_q;
    logic [NUM_INT-1:0] src_d;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] clr_w1c;
    logic [NUM_INT-1:0] claim_hot;
    logic [NUM_INT-1:0] pend_clr;
    logic               wr_mode_hit;
    logic               wr_pend_hit;
    logic               rd_claim;

    assign wr_mode_hit = wr_en && (WB_WR_ADR_I == ADR_MODE);
    assign wr_pend_hit = wr_en && (WB_WR_ADR_I == ADR_PENDING);
    assign rd_claim    = WB_RD_STB_I && (WB_RD_ADR_I == ADR_CLAIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
            src_d  <= '0;
        end else if (sync_reset) begin
            mode_q <= '0;
            src_d  <= '0;
        end else begin
            src_d <= src_s;
            if (wr_mode_hit) begin
                mode_q <= (mode_q & ~wr_mask[NUM_INT-1:0]) | wr_bits[NUM_INT-1:0];
            end
        end
    end

    assign mode_w    = mode_q;
    assign rise      = src_s & ~src_d;
    assign clr_w1c   = wr_pend_hit ? wr_bits[NUM_INT-1:0] : '0;
    // The claim clears whatever int_id currently reports, which is the
    // same value being returned on this read.
    assign claim_hot = (rd_claim && int_gen) ? (NUM_INT'(1) << int_id) : '0;
    assign pend_clr  = (clr_w1c | claim_hot) & mode_q;

    // Level bits track the source; edge bits are sticky with set priority.
    assign pending_next = (~mode_q & src_s)
                        | ( mode_q & ((pending_q & ~pend_clr) | rise));
`else
    assign mode_w       = '0;
    assign pending_next = src_s;
`endif

    assign active = pending_q & enable_q;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        prio_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (active[i]) begin
                prio_id = ID_W'(i);
            end
        end
    end

    logic [XLEN-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (WB_RD_ADR_I)
            ADR_SOURCE:  rd_word[NUM_INT-1:0] = src_s;
            ADR_ENABLE:  rd_word[NUM_INT-1:0] = enable_q;
            ADR_PENDING: rd_word[NUM_INT-1:0] = pending_q;
            ADR_MODE:    rd_word[NUM_INT-1:0] = mode_w;
            ADR_CLAIM: begin
                if (int_gen) begin
                    rd_word[ID_W:0] = {1'b0, int_id} + (ID_W+1)'(1);
                end
            end
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q    <= '0;
            pending_q   <= '0;
            int_gen     <= 1'b0;
            int_id      <= '0;
            WB_RD_DAT_O <= '0;
            WB_RD_ACK_O <= 1'b0;
            WB_WR_ACK_O <= 1'b0;
        end else if (sync_reset) begin
            enable_q    <= '0;
            pending_q   <= '0;
            int_gen     <= 1'b0;
            int_id      <= '0;
            WB_RD_DAT_O <= '0;
            WB_RD_ACK_O <= 1'b0;
            WB_WR_ACK_O <= 1'b0;
        end else begin
            if (wr_enable_hit) begin
                enable_q <= (enable_q & ~wr_mask[NUM_INT-1:0]) | wr_bits[NUM_INT-1:0];
            end
            pending_q   <= pending_next;
            int_gen     <= |active;
            int_id      <= prio_id;
            WB_WR_ACK_O <= wr_en;
            WB_RD_ACK_O <= WB_RD_STB_I;
            WB_RD_DAT_O <= WB_RD_STB_I ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_peripherals_intc.sv
// ---------------------------------------------------------------------------
// tb_peripherals_intc
//
// Directed bench for peripherals_intc (NUM_INT=8, SYNC_STAGES=2,
// BASE_ADDR=8'h20). A behavioural model keeps an irq sample history and the
// register contents as plain bytes; a negedge process compares the DUT
// outputs against it every cycle, and the directed sequence adds literal
// expectations for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_peripherals_intc;

    localparam int NI = 8;
    localparam int SS = 2;

`ifdef INTC_EDGE_MODE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync_reset = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        rd_stb = 1'b0;
    logic [7:0]  rd_adr = '0;
    logic [31:0] rd_dat;
    logic        rd_ack;
    logic        wr_stb = 1'b0;
    logic        wr_we = 1'b0;
    logic [3:0]  wr_sel = '0;
    logic [7:0]  wr_adr = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_ack;
    logic        int_gen;
    logic [2:0]  int_id;

    int checks = 0;
    int errors = 0;

    peripherals_intc #(
        .NUM_INT(NI), .SYNC_STAGES(SS), .XLEN(32), .ADDR_BITS(8), .BASE_ADDR(8'h20)
    ) dut (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .irq_in(irq_in),
        .WB_RD_STB_I(rd_stb), .WB_RD_ADR_I(rd_adr), .WB_RD_DAT_O(rd_dat),
        .WB_RD_ACK_O(rd_ack), .WB_WR_STB_I(wr_stb), .WB_WR_WE_I(wr_we),
        .WB_WR_SEL_I(wr_sel), .WB_WR_ADR_I(wr_adr), .WB_WR_DAT_I(wr_dat),
        .WB_WR_ACK_O(wr_ack), .int_gen(int_gen), .int_id(int_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] = irq_in sampled k+1 edges ago; the synchronised view after
    // SS edges is hist[SS-1], its one-cycle-older copy hist[SS].
    logic [7:0]  hist [0:3];
    logic [7:0]  m_en = '0, m_mode = '0, m_pend = '0;
    logic        m_gen = 1'b0, m_rd_ack = 1'b0, m_wr_ack = 1'b0;
    int          m_id = 0;
    logic [31:0] m_rd_dat = '0;

    initial for (int k = 0; k < 4; k++) hist[k] = '0;

    always @(posedge clk or posedge reset) begin : model
        logic [7:0]  s, d, rise, act, lane, wb, clr, pn;
        logic [31:0] rv;
        int          idx;
        bit          wr;
        if (reset || sync_reset) begin
            for (int k = 0; k < 4; k++) hist[k] = '0;
            m_en = '0; m_mode = '0; m_pend = '0;
            m_gen = 1'b0; m_id = 0; m_rd_ack = 1'b0; m_wr_ack = 1'b0; m_rd_dat = '0;
        end else begin
            s    = hist[SS-1];
            d    = hist[SS];
            rise = EDGE ? (s & ~d) : 8'h00;
            act  = m_pend & m_en;
            idx  = 0;
            while (idx < NI && !act[idx]) idx++;
            wr   = wr_stb && wr_we;
            lane = wr_sel[0] ? 8'hFF : 8'h00;
            wb   = wr_dat[7:0] & lane;

            rv = 32'h0;
            case (rd_adr)
                8'h20: rv = {24'h0, s};
                8'h21: rv = {24'h0, m_en};
                8'h22: rv = {24'h0, m_pend};
                8'h23: rv = {24'h0, m_mode};
                8'h24: rv = m_gen ? 32'(m_id + 1) : 32'h0;
                default: rv = 32'h0;
            endcase

            clr = 8'h00;
            if (EDGE && wr && wr_adr == 8'h22) clr = clr | wb;
            if (EDGE && rd_stb && rd_adr == 8'h24 && m_gen) clr[m_id] = 1'b1;
            for (int i = 0; i < NI; i++)
                pn[i] = m_mode[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : s[i];

            m_rd_ack = rd_stb;
            m_wr_ack = wr;
            m_rd_dat = rd_stb ? rv : 32'h0;
            m_gen    = (act != 0);
            m_id     = (act != 0) ? idx : 0;
            m_pend   = pn;
            if (wr && wr_adr == 8'h21) m_en = (m_en & ~lane) | wb;
            if (EDGE && wr && wr_adr == 8'h23) m_mode = (m_mode & ~lane) | wb;
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = irq_in;
        end
    end

    bit run = 1'b0;

    always @(negedge clk) begin
        if (run) begin
            chk("cmp_int_gen", {31'h0, int_gen}, {31'h0, m_gen});
            chk("cmp_int_id", {29'h0, int_id}, 32'(m_id));
            chk("cmp_rd_ack", {31'h0, rd_ack}, {31'h0, m_rd_ack});
            chk("cmp_wr_ack", {31'h0, wr_ack}, {31'h0, m_wr_ack});
            if (m_rd_ack) chk("cmp_rd_dat", rd_dat, m_rd_dat);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wr_reg(input logic [7:0] a, input logic [31:0] dv, input logic [3:0] sel);
        @(negedge clk);
        wr_stb = 1'b1; wr_we = 1'b1; wr_adr = a; wr_dat = dv; wr_sel = sel;
        @(negedge clk);
        wr_stb = 1'b0; wr_we = 1'b0; wr_sel = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_stb = 1'b1; rd_adr = a;
        @(negedge clk);
        chk({nm, "_ack"}, {31'h0, rd_ack}, 32'h1);
        chk(nm, rd_dat, exp);
        rd_stb = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        run = 1'b1;
        chk("rst_int_gen", {31'h0, int_gen}, 32'h0);
        chk("rst_rd_ack", {31'h0, rd_ack}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // enable source 2, check 4-edge latency both ways and claim value
        wr_reg(8'h21, 32'h04, 4'b0001);
        rd_chk("enable_rb", 8'h21, 32'h04);
        irq_in[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_rise_e3", {31'h0, int_gen}, 32'h0);
        @(posedge clk);
        #1 chk("lat_rise_e4", {31'h0, int_gen}, 32'h1);
        chk("lat_rise_id", {29'h0, int_id}, 32'h2);
        rd_chk("claim_lvl", 8'h24, 32'h3);
        irq_in[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("lat_fall_e3", {31'h0, int_gen}, 32'h1);
        @(posedge clk);
        #1 chk("lat_fall_e4", {31'h0, int_gen}, 32'h0);

        // level priority between sources 3 and 5
        irq_in[3] = 1'b1; irq_in[5] = 1'b1;
        wr_reg(8'h21, 32'h28, 4'b0001);
        repeat (6) @(negedge clk);
        chk("prio_id_3", {29'h0, int_id}, 32'h3);
        rd_chk("claim_3", 8'h24, 32'h4);
        rd_chk("source_rb", 8'h20, 32'h28);
        wr_reg(8'h21, 32'h20, 4'b0001);
        chk("prio_id_hold", {29'h0, int_id}, 32'h3);
        @(posedge clk);
        #1 chk("prio_id_5", {29'h0, int_id}, 32'h5);

        // byte lanes, upper bits, unmapped addresses
        wr_reg(8'h21, 32'hFFFF_FFFF, 4'b0001);
        rd_chk("enable_lane0", 8'h21, 32'h0000_00FF);
        wr_reg(8'h21, 32'h0, 4'b1110);
        rd_chk("enable_lane_off", 8'h21, 32'h0000_00FF);
        wr_reg(8'h26, 32'hFF, 4'b1111);
        rd_chk("unmapped_26", 8'h26, 32'h0);
        rd_chk("unmapped_1f", 8'h1F, 32'h0);

`ifdef INTC_EDGE_MODE_EN
        irq_in = '0;
        wr_reg(8'h21, 32'h01, 4'b0001);
        wr_reg(8'h23, 32'h01, 4'b0001);
        repeat (5) @(negedge clk);
        irq_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        irq_in[0] = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk("edge_pend_held", 8'h22, 32'h01);
        chk("edge_int_gen", {31'h0, int_gen}, 32'h1);
        rd_chk("edge_claim", 8'h24, 32'h1);
        rd_chk("edge_pend_clr", 8'h22, 32'h0);
        chk("edge_gen_low", {31'h0, int_gen}, 32'h0);

        // W1C on bit 1 colliding with a new rise: set wins
        wr_reg(8'h23, 32'h03, 4'b0001);
        irq_in[1] = 1'b1;
        @(negedge clk);
        irq_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        rd_chk("w1c_pre", 8'h22, 32'h02);
        irq_in[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr_reg(8'h22, 32'h02, 4'b0001);
        rd_chk("w1c_vs_rise", 8'h22, 32'h02);
        irq_in[1] = 1'b0;
        wr_reg(8'h22, 32'h02, 4'b0000);
        rd_chk("w1c_no_lane", 8'h22, 32'h02);
        wr_reg(8'h22, 32'h02, 4'b0001);
        rd_chk("w1c_clear", 8'h22, 32'h00);
`else
        wr_reg(8'h23, 32'hFF, 4'b0001);
        rd_chk("mode_absent", 8'h23, 32'h0);
        wr_reg(8'h21, 32'h08, 4'b0001);
        repeat (2) @(negedge clk);
        wr_reg(8'h22, 32'h08, 4'b0001);
        rd_chk("w1c_ignored", 8'h22, 32'h28);
        rd_chk("claim_no_clr1", 8'h24, 32'h4);
        rd_chk("claim_no_clr2", 8'h24, 32'h4);
`endif

        // synchronous clear
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        chk("sync_rst_gen", {31'h0, int_gen}, 32'h0);
        rd_chk("sync_rst_enable", 8'h21, 32'h0);

        // async reset in the middle of a read
        wr_reg(8'h21, 32'hFF, 4'b0001);
        irq_in = 8'h10;
        repeat (6) @(negedge clk);
        rd_stb = 1'b1; rd_adr = 8'h21;
        @(posedge clk);
        #1 chk("mid_ack_before", {31'h0, rd_ack}, 32'h1);
        reset = 1'b1;
        rd_stb = 1'b0;
        #1 chk("mid_ack_dropped", {31'h0, rd_ack}, 32'h0);
        chk("mid_gen_dropped", {31'h0, int_gen}, 32'h0);
        chk("mid_rd_dat", rd_dat, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_chk("post_rst_21", 8'h21, 32'h0);

        repeat (3) @(negedge clk);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
